// File: rtl/fifo_arbiter_pkg.sv
// fifo_arbiter_pkg: shared constants and helpers for fifo_arbiter.
// Holds the arbitration mode codes and a constant-safe clog2.
package fifo_arbiter_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/arb_fifo.sv
// arb_fifo: one channel's input FIFO with full/almost-full/overflow flags.
// Ports: clk, rst, push/d (write), pop/head/empty (read), full, almost_full, overflow.
module arb_fifo
  import fifo_arbiter_pkg::*;
#(
  parameter int W         = 8,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] d,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full,
  output logic         almost_full,
  output logic         overflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int AF_RAW =
    (AF_MARGIN >= DEPTH) ? 0 : DEPTH - AF_MARGIN;
  localparam logic [CW-1:0] AF_TH  = CW'(AF_RAW);
  localparam logic [CW-1:0] FULL_N = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic          w_wr;
  logic          w_rd;

  assign full        = (r_cnt == FULL_N);
  assign empty       = (r_cnt == '0);
  assign almost_full = (r_cnt >= AF_TH);
  assign overflow    = r_ovf;
  assign head        = r_mem[r_rp];

  // full is the pre-edge state: a push on a full FIFO is
  // dropped even when the same edge pops it.
  assign w_wr = push && !full;
  assign w_rd = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      if (w_wr && !w_rd) r_cnt <= r_cnt + CW'(1);
      if (!w_wr && w_rd) r_cnt <= r_cnt - CW'(1);
      if (push && full) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= d;
  end

endmodule

// File: rtl/fifo_arbiter.sv
// fifo_arbiter: N input FIFOs arbitrated into one registered stream.
// Ports: push/d in, full/almost_full/overflow flags, q/q_id/valid out, stall in.
module fifo_arbiter
  import fifo_arbiter_pkg::*;
#(
  parameter int N         = 8,
  parameter int W         = 8,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2,
  parameter int RR        = ARB_RR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [0:N-1]          push,
  input  logic [N*W-1:0]        d,
  output logic [0:N-1]          full,
  output logic [0:N-1]          almost_full,
  output logic [0:N-1]          overflow,
  output logic [W-1:0]          q,
  output logic [clog2(N)-1:0]   q_id,
  output logic                  valid,
  input  logic                  stall
);

  localparam int IW = clog2(N);

  logic [0:N-1]  w_empty;
  logic [0:N-1]  w_pop;
  logic [W-1:0]  w_head [N];
  logic [IW-1:0] w_gnt;
  logic          w_gnt_vld;
  logic          w_load;

  logic [IW-1:0] r_last;
  logic [W-1:0]  r_q;
  logic [IW-1:0] r_id;
  logic          r_valid;

  for (genvar i = 0; i < N; i++) begin : g_ch
    arb_fifo #(
      .W        (W),
      .DEPTH    (DEPTH),
      .AF_MARGIN(AF_MARGIN)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push[i]),
      .d          (d[(N-i)*W-1 -: W]),
      .pop        (w_pop[i]),
      .head       (w_head[i]),
      .empty      (w_empty[i]),
      .full       (full[i]),
      .almost_full(almost_full[i]),
      .overflow   (overflow[i])
    );
  end

  // Loops scan from the far end so the nearest candidate is
  // the last assignment and therefore wins.
  always_comb begin
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    if (RR == ARB_RR) begin
      for (int k = N; k >= 1; k--) begin
        if (!w_empty[IW'((int'(r_last) + k) % N)]) begin
          w_gnt     = IW'((int'(r_last) + k) % N);
          w_gnt_vld = 1'b1;
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (!w_empty[i]) begin
          w_gnt     = IW'(i);
          w_gnt_vld = 1'b1;
        end
      end
    end
  end

  assign w_load = !r_valid || !stall;

  always_comb begin
    w_pop = '0;
    if (w_load && w_gnt_vld) w_pop[w_gnt] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_q     <= '0;
      r_id    <= '0;
      r_last  <= IW'(N - 1);
    end else if (w_load) begin
      if (w_gnt_vld) begin
        r_valid <= 1'b1;
        r_q     <= w_head[w_gnt];
        r_id    <= w_gnt;
        r_last  <= w_gnt;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign q     = r_q;
  assign q_id  = r_id;
  assign valid = r_valid;

endmodule

// File: tb/tb_fifo_arbiter.sv
// tb_fifo_arbiter: scenario and random checks of fifo_arbiter
// in round-robin (m=0) and fixed-priority (m=1) modes.
module tb_fifo_arbiter;

  localparam int N     = 8;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int AFM   = 1;
  localparam int IW    = 3;

  logic           clk   = 1'b0;
  logic           rst   = 1'b1;
  logic           stall = 1'b0;
  logic [0:N-1]   push  = '0;
  logic [N*W-1:0] d     = '0;

  logic           dv  [2];
  logic [W-1:0]   dq  [2];
  logic [IW-1:0]  did [2];
  logic [0:N-1]   df  [2];
  logic [0:N-1]   daf [2];
  logic [0:N-1]   dov [2];

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] mq [2][N][$];
  bit           mv   [2];
  logic [W-1:0] mo   [2];
  int           mid  [2];
  int           ml   [2];
  bit           movf [2][N];

  always #5 clk = ~clk;

  fifo_arbiter #(
    .N(N), .W(W), .DEPTH(DEPTH), .AF_MARGIN(AFM), .RR(1)
  ) u_rr (
    .clk(clk), .rst(rst), .push(push), .d(d),
    .full(df[0]), .almost_full(daf[0]), .overflow(dov[0]),
    .q(dq[0]), .q_id(did[0]), .valid(dv[0]), .stall(stall)
  );

  fifo_arbiter #(
    .N(N), .W(W), .DEPTH(DEPTH), .AF_MARGIN(AFM), .RR(0)
  ) u_fx (
    .clk(clk), .rst(rst), .push(push), .d(d),
    .full(df[1]), .almost_full(daf[1]), .overflow(dov[1]),
    .q(dq[1]), .q_id(did[1]), .valid(dv[1]), .stall(stall)
  );

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic put(input int ch, input logic [W-1:0] v);
    push[ch] = 1'b1;
    d[(N-ch)*W-1 -: W] = v;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < N; i++) begin
        mq[m][i].delete();
        movf[m][i] = 1'b0;
      end
      mv[m]  = 1'b0;
      mo[m]  = '0;
      mid[m] = 0;
      ml[m]  = N - 1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    push = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Apply one clock edge to the reference model and the DUTs.
  task automatic tick();
    for (int m = 0; m < 2; m++) begin
      int sz [N];
      int win;
      bit ld;
      for (int i = 0; i < N; i++) sz[i] = mq[m][i].size();
      ld  = !mv[m] || !stall;
      win = -1;
      if (ld) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m == 0) ? (ml[m] + k) % N : k - 1;
          if (win < 0 && sz[c] > 0) win = c;
        end
        if (win >= 0) begin
          mv[m]  = 1'b1;
          mo[m]  = mq[m][win].pop_front();
          mid[m] = win;
          ml[m]  = win;
        end else begin
          mv[m] = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (push[i]) begin
          if (sz[i] < DEPTH) mq[m][i].push_back(d[(N-i)*W-1 -: W]);
          else movf[m][i] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    push = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    push = '0;
    stall = 1'b0;
    model_reset();
    #12;
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (dv[m] !== 1'b0 || dq[m] !== '0 || did[m] !== '0) begin
        n_fail++;
        $display("FAIL reset_out m=%0d got v=%0b q=%h id=%0d exp 0/00/0",
                 m, dv[m], dq[m], did[m]);
      end
      n_chk++;
      if (df[m] !== '0 || daf[m] !== '0 || dov[m] !== '0) begin
        n_fail++;
        $display("FAIL reset_flags m=%0d got f=%b af=%b ov=%b exp all 0",
                 m, df[m], daf[m], dov[m]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_serial_fill();
    bit ev;
    do_reset();
    stall = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) put(0, W'(c));
      tick();
      ev = (c >= 1 && c <= 8);
      for (int m = 0; m < 2; m++) begin
        n_chk++;
        if (dv[m] !== ev) begin
          n_fail++;
          $display("FAIL serial_valid m=%0d c=%0d got=%0b exp=%0b",
                   m, c, dv[m], ev);
        end
        if (ev) begin
          n_chk++;
          if (dq[m] !== W'(c - 1) || did[m] !== '0) begin
            n_fail++;
            $display("FAIL serial_data m=%0d got q=%h id=%0d exp q=%h id=0",
                     m, dq[m], did[m], W'(c - 1));
          end
        end
      end
    end
  endtask

  task automatic test_rr_fairness();
    int           chs  [3] = '{0, 3, 5};
    logic [W-1:0] base [3] = '{8'hA0, 8'hD0, 8'hF0};
    int           ech;
    logic [W-1:0] edat;
    do_reset();
    stall = 1'b1;
    for (int r = 0; r < 4; r++) begin
      put(0, 8'hA0 + W'(r));
      put(3, 8'hD0 + W'(r));
      put(5, 8'hF0 + W'(r));
      tick();
    end
    for (int j = 0; j < 12; j++) begin
      for (int m = 0; m < 2; m++) begin
        if (m == 0) begin
          ech  = chs[j % 3];
          edat = base[j % 3] + W'(j / 3);
        end else begin
          ech  = chs[j / 4];
          edat = base[j / 4] + W'(j % 4);
        end
        n_chk++;
        if (dv[m] !== 1'b1 || did[m] !== IW'(ech) || dq[m] !== edat) begin
          n_fail++;
          $display("FAIL arb_order m=%0d j=%0d got v=%0b id=%0d q=%h exp id=%0d q=%h",
                   m, j, dv[m], did[m], dq[m], ech, edat);
        end
      end
      stall = 1'b0;
      tick();
    end
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (dv[m] !== 1'b0) begin
        n_fail++;
        $display("FAIL arb_drained m=%0d got v=%0b exp 0", m, dv[m]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [0:N-1] eaf;
    logic [0:N-1] ef;
    int           nout [2];
    do_reset();
    stall = 1'b0;
    put(1, 8'h11); put(6, 8'h61); tick();
    put(1, 8'h12); put(6, 8'h62); tick();
    stall = 1'b1;
    put(6, 8'h63); tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < N; i++) begin
          ef[i]  = (mq[m][i].size() == DEPTH);
          eaf[i] = (mq[m][i].size() >= DEPTH - AFM);
        end
        n_chk++;
        if (dv[m] !== 1'b1 || dq[m] !== 8'h11 || did[m] !== IW'(1)) begin
          n_fail++;
          $display("FAIL bp_hold m=%0d got v=%0b q=%h id=%0d exp 1/11/1",
                   m, dv[m], dq[m], did[m]);
        end
        n_chk++;
        if (df[m] !== ef || daf[m] !== eaf) begin
          n_fail++;
          $display("FAIL bp_flags m=%0d got f=%b af=%b exp f=%b af=%b",
                   m, df[m], daf[m], ef, eaf);
        end
      end
    end
    stall = 1'b0;
    nout[0] = 1;
    nout[1] = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        if (dv[m] === 1'b1) nout[m]++;
        n_chk++;
        if (dv[m] !== mv[m] ||
            (mv[m] && (dq[m] !== mo[m] || did[m] !== IW'(mid[m])))) begin
          n_fail++;
          $display("FAIL bp_drain m=%0d got v=%0b q=%h id=%0d exp v=%0b q=%h id=%0d",
                   m, dv[m], dq[m], did[m], mv[m], mo[m], mid[m]);
        end
      end
    end
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (nout[m] != 5) begin
        n_fail++;
        $display("FAIL bp_count m=%0d got=%0d exp=5", m, nout[m]);
      end
    end
  endtask

  task automatic test_full_overflow();
    int n2 [2];
    do_reset();
    stall = 1'b1;
    put(0, 8'h55); tick();
    tick();
    for (int p = 1; p <= 5; p++) begin
      put(2, 8'h20 + W'(p - 1));
      tick();
      for (int m = 0; m < 2; m++) begin
        n_chk++;
        if (daf[m][2] !== (p >= 3) || df[m][2] !== (p >= 4) ||
            dov[m][2] !== (p >= 5)) begin
          n_fail++;
          $display("FAIL fill_flags m=%0d p=%0d got af=%0b f=%0b ov=%0b exp %0b/%0b/%0b",
                   m, p, daf[m][2], df[m][2], dov[m][2],
                   p >= 3, p >= 4, p >= 5);
        end
      end
    end
    stall = 1'b0;
    n2[0] = 0;
    n2[1] = 0;
    for (int c = 0; c < 7; c++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        if (dv[m] === 1'b1 && did[m] === IW'(2)) begin
          n_chk++;
          if (dq[m] !== 8'h20 + W'(n2[m])) begin
            n_fail++;
            $display("FAIL fill_data m=%0d got=%h exp=%h",
                     m, dq[m], 8'h20 + W'(n2[m]));
          end
          n2[m]++;
        end
      end
    end
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (n2[m] != 4) begin
        n_fail++;
        $display("FAIL fill_count m=%0d got=%0d exp=4", m, n2[m]);
      end
    end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    stall = 1'b1;
    for (int p = 0; p < 5; p++) begin
      put(1, 8'h10 + W'(p));
      tick();
    end
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (df[m][1] !== 1'b1 || dq[m] !== 8'h10) begin
        n_fail++;
        $display("FAIL ppf_setup m=%0d got f=%0b q=%h exp 1/10",
                 m, df[m][1], dq[m]);
      end
    end
    stall = 1'b0;
    put(1, 8'h1F);
    tick();
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (dov[m][1] !== 1'b1 || df[m][1] !== 1'b0 ||
          daf[m][1] !== 1'b1 || dq[m] !== 8'h11) begin
        n_fail++;
        $display("FAIL ppf_edge m=%0d got ov=%0b f=%0b af=%0b q=%h exp 1/0/1/11",
                 m, dov[m][1], df[m][1], daf[m][1], dq[m]);
      end
    end
    for (int j = 1; j <= 4; j++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        n_chk++;
        if (j < 4 && (dv[m] !== 1'b1 || dq[m] !== 8'h11 + W'(j))) begin
          n_fail++;
          $display("FAIL ppf_drain m=%0d j=%0d got v=%0b q=%h exp q=%h",
                   m, j, dv[m], dq[m], 8'h11 + W'(j));
        end else if (j == 4 && dv[m] !== 1'b0) begin
          n_fail++;
          $display("FAIL ppf_end m=%0d got v=%0b q=%h exp v=0",
                   m, dv[m], dq[m]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [0:N-1] ef;
    logic [0:N-1] eaf;
    logic [0:N-1] eov;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c % 100 == 99) do_reset();
      stall = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 4) < 2) put(i, W'($urandom));
      end
      tick();
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < N; i++) begin
          ef[i]  = (mq[m][i].size() == DEPTH);
          eaf[i] = (mq[m][i].size() >= DEPTH - AFM);
          eov[i] = movf[m][i];
        end
        n_chk++;
        if (dv[m] !== mv[m] ||
            (mv[m] && (dq[m] !== mo[m] || did[m] !== IW'(mid[m])))) begin
          n_fail++;
          $display("FAIL rand_out m=%0d c=%0d got v=%0b q=%h id=%0d exp v=%0b q=%h id=%0d",
                   m, c, dv[m], dq[m], did[m], mv[m], mo[m], mid[m]);
        end
        n_chk++;
        if (df[m] !== ef || daf[m] !== eaf || dov[m] !== eov) begin
          n_fail++;
          $display("FAIL rand_flags m=%0d c=%0d got %b/%b/%b exp %b/%b/%b",
                   m, c, df[m], daf[m], dov[m], ef, eaf, eov);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    stall = 1'b1;
    for (int p = 0; p < 5; p++) begin
      if (p < 2) begin
        put(2, 8'h22 + W'(p));
        put(7, 8'h77 + W'(p));
      end
      put(4, 8'h44 + W'(p));
      tick();
    end
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (dv[m] !== 1'b1 || dov[m][4] !== 1'b1) begin
        n_fail++;
        $display("FAIL midrst_setup m=%0d got v=%0b ov4=%0b exp 1/1",
                 m, dv[m], dov[m][4]);
      end
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (dv[m] !== 1'b0 || dq[m] !== '0 || did[m] !== '0 ||
          df[m] !== '0 || daf[m] !== '0 || dov[m] !== '0) begin
        n_fail++;
        $display("FAIL midrst_clear m=%0d got v=%0b q=%h id=%0d f=%b af=%b ov=%b exp all 0",
                 m, dv[m], dq[m], did[m], df[m], daf[m], dov[m]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    stall = 1'b0;
    put(0, 8'h5A);
    put(7, 8'hE7);
    tick();
    tick();
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (dv[m] !== 1'b1 || dq[m] !== 8'h5A || did[m] !== '0) begin
        n_fail++;
        $display("FAIL midrst_first m=%0d got v=%0b q=%h id=%0d exp 1/5a/0",
                 m, dv[m], dq[m], did[m]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_serial_fill();
    test_rr_fairness();
    test_backpressure();
    test_full_overflow();
    test_push_pop_full();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
